// File: rtl/axilite_sram_init.sv
// rtl/axilite_sram_init.sv - AXI-Lite write master that fills SRAM_DEPTH words with a constant or incrementing pattern
// Define SRAM_INIT_ABORT_EN to end a run at the first non-OKAY write response.
module axilite_sram_init #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRAM_DEPTH = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   pattern,
    input  logic                    incr,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             err_cnt,
    output logic                    abort,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bvalid,
    input  logic [1:0]              m_axi_bresp,
    output logic                    m_axi_bready
);

    localparam int IDX_W = $clog2(SRAM_DEPTH);
`ifdef SRAM_INIT_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        index;
    logic [IDX_W-1:0]        index_nxt;
    logic [DATA_WIDTH-1:0]   pat;
    logic                    inc;
    logic                    aw_done;
    logic                    w_done;
    logic                    abort_q;
    logic                    bad_resp;
    logic                    last_word;

    assign index_nxt = index + IDX_W'(1);
    assign bad_resp  = (m_axi_bresp != 2'b00);
    assign last_word = (index == IDX_W'(SRAM_DEPTH - 1));
    assign abort     = ABORT_EN ? abort_q : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            pat           <= '0;
            inc           <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            abort_q       <= 1'b0;
            err_cnt       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= ISSUE;
                        index         <= '0;
                        pat           <= pattern;
                        inc           <= incr;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        abort_q       <= 1'b0;
                        err_cnt       <= '0;
                        busy          <= 1'b1;
                        m_axi_awaddr  <= BASE_ADDR;
                        m_axi_wdata   <= pattern;
                        m_axi_wstrb   <= {(DATA_WIDTH/8){1'b1}};
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // AW and W retire independently; RESP waits until both flags are set
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_done && w_done) begin
                        state        <= RESP;
                        m_axi_bready <= 1'b1;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        m_axi_bready <= 1'b0;
                        if (bad_resp && err_cnt != 16'hFFFF)
                            err_cnt <= err_cnt + 16'd1;
                        if ((ABORT_EN && bad_resp) || last_word) begin
                            if (ABORT_EN && bad_resp)
                                abort_q <= 1'b1;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            index         <= index_nxt;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            m_axi_awaddr  <= BASE_ADDR + (ADDR_WIDTH'(index_nxt) << 2);
                            m_axi_wdata   <= inc ? pat + DATA_WIDTH'(index_nxt) : pat;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
